// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// All outputs registered; each serial bit lasts the latched divisor (0 treated as 1) in cycles.
module uart_tx_engine #(
   parameter int DATA_UART = 8,
   parameter int DIV_SIZE  = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 en_i,
   input  logic                 stop_bits_i,
   input  logic                 parity_bit_i,
   input  logic                 parity_bit_mode_i,
   input  logic [DIV_SIZE-1:0]  baud_div_i,
   input  logic [DATA_UART-1:0] tx_data_i,
   input  logic                 tx_send_i,
   output logic                 tx_o,
   output logic                 tx_ready_o,
   output logic                 busy_o
);

   localparam int IDX_W = (DATA_UART > 1) ? $clog2(DATA_UART) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t               state_q, state_d;
   logic [DIV_SIZE-1:0]  cnt_q, cnt_d;
   logic [DIV_SIZE-1:0]  div_q, div_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_UART-1:0] shift_q, shift_d;
   logic                 stop2_q, stop2_d;
   logic                 par_en_q, par_en_d;
   logic                 par_val_q, par_val_d;
   logic                 tx_d, busy_d, ready_d;
   logic                 bit_end;

   // div_q is never zero, so div_q-1 cannot underflow
   assign bit_end = (cnt_q == div_q - DIV_SIZE'(1));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         div_q      <= DIV_SIZE'(1);
         idx_q      <= '0;
         shift_q    <= '0;
         stop2_q    <= 1'b0;
         par_en_q   <= 1'b0;
         par_val_q  <= 1'b0;
         tx_o       <= 1'b1;
         busy_o     <= 1'b0;
         tx_ready_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         stop2_q    <= stop2_d;
         par_en_q   <= par_en_d;
         par_val_q  <= par_val_d;
         tx_o       <= tx_d;
         busy_o     <= busy_d;
         tx_ready_o <= ready_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      stop2_d   = stop2_q;
      par_en_d  = par_en_q;
      par_val_d = par_val_q;
      tx_d      = tx_o;
      busy_d    = busy_o;
      ready_d   = 1'b0;

      if (state_q == IDLE) begin
         tx_d   = 1'b1;
         busy_d = 1'b0;
         cnt_d  = '0;
         idx_d  = '0;
         if (en_i && tx_send_i) begin
            state_d   = START;
            shift_d   = tx_data_i;
            stop2_d   = stop_bits_i;
            par_en_d  = parity_bit_i;
            // parity is fixed at latch time so the shifting data need not be kept
            par_val_d = (^tx_data_i) ^ parity_bit_mode_i;
            div_d     = (baud_div_i == '0) ? DIV_SIZE'(1) : baud_div_i;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
         end
      end else if (!en_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
         tx_d    = 1'b1;
         busy_d  = 1'b0;
      end else if (!bit_end) begin
         cnt_d = cnt_q + DIV_SIZE'(1);
      end else begin
         cnt_d = '0;
         case (state_q)
            START: begin
               state_d = DATA;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end
            DATA: begin
               if (idx_q == IDX_W'(DATA_UART - 1)) begin
                  state_d = par_en_q ? PARITY : STOP1;
                  tx_d    = par_en_q ? par_val_q : 1'b1;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
               end
            end
            PARITY: begin
               state_d = STOP1;
               tx_d    = 1'b1;
            end
            STOP1: begin
               tx_d = 1'b1;
               if (stop2_q) begin
                  state_d = STOP2;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end
            end
            STOP2: begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

endmodule
